// File: rtl/key_pkg.sv
// Shared constants and types for the push-button debounce front end.
// Board defaults assume the 12 MHz system clock.
package key_pkg;

   localparam int KEY_DB_CYCLES_12M   = 240_000;     // 20 ms of stable level
   localparam int KEY_LONG_CYCLES_12M = 12_000_000;  // 1 s held

   // +1 so the counter width always covers the count with headroom (2^W > N)
   localparam int KEY_DB_WIDTH   = $clog2(KEY_DB_CYCLES_12M + 1);
   localparam int KEY_LONG_WIDTH = $clog2(KEY_LONG_CYCLES_12M + 1);

   // Pin level that means "pressed" on the board
   localparam logic KEY_PRESSED = 1'b0;

   typedef struct packed {
      logic level;
      logic press;
      logic rel;
      logic long_p;
      logic toggle;
   } key_evt_t;

endpackage

// File: rtl/key_debounce_one.sv
// Single key channel: 2-flop synchroniser, stable-count debounce, hold timer,
// registered press/release/long pulses and a press-driven toggle flag.
module key_debounce_one
   import key_pkg::*;
#(
   parameter int DB_CYCLES   = KEY_DB_CYCLES_12M,
   parameter int DB_WIDTH    = KEY_DB_WIDTH,
   parameter int LONG_CYCLES = KEY_LONG_CYCLES_12M,
   parameter int LONG_WIDTH  = KEY_LONG_WIDTH
)(
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_toggle
);

   localparam logic [DB_WIDTH-1:0]   DB_LAST   = DB_WIDTH'(DB_CYCLES - 1);
   localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_CYCLES - 1);

   logic [1:0]            sync_reg;
   logic                  key_s;
   logic                  flip;
   logic [DB_WIDTH-1:0]   db_cnt_reg, db_cnt_next;
   logic [LONG_WIDTH-1:0] hold_cnt_reg, hold_cnt_next;
   key_evt_t              evt_reg, evt_next;

   assign key_s = (sync_reg[1] == KEY_PRESSED);

   always_comb begin
      db_cnt_next   = db_cnt_reg;
      hold_cnt_next = hold_cnt_reg;
      evt_next      = evt_reg;
      evt_next.press  = 1'b0;
      evt_next.rel    = 1'b0;
      evt_next.long_p = 1'b0;
      flip          = 1'b0;

      // Any cycle that agrees with the accepted level restarts the count
      if (key_s == evt_reg.level) begin
         db_cnt_next = '0;
      end else if (db_cnt_reg == DB_LAST) begin
         db_cnt_next = '0;
         flip        = 1'b1;
      end else begin
         db_cnt_next = db_cnt_reg + 1'b1;
      end

      if (flip) begin
         evt_next.level = key_s;
         evt_next.press = key_s;
         evt_next.rel   = ~key_s;
         if (key_s) begin
            evt_next.toggle = ~evt_reg.toggle;
         end
         hold_cnt_next = '0;
      end else if (!evt_reg.level) begin
         hold_cnt_next = '0;
      end else if (hold_cnt_reg != LONG_LAST) begin
         // Saturating at LONG_LAST makes the long pulse fire once per press
         hold_cnt_next   = hold_cnt_reg + 1'b1;
         evt_next.long_p = (hold_cnt_next == LONG_LAST);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg     <= {2{~KEY_PRESSED}};
         db_cnt_reg   <= '0;
         hold_cnt_reg <= '0;
         evt_reg      <= '0;
      end else begin
         sync_reg     <= {sync_reg[0], key_n};
         db_cnt_reg   <= db_cnt_next;
         hold_cnt_reg <= hold_cnt_next;
         evt_reg      <= evt_next;
      end
   end

   assign key_level   = evt_reg.level;
   assign key_press   = evt_reg.press;
   assign key_release = evt_reg.rel;
   assign key_long    = evt_reg.long_p;
   assign key_toggle  = evt_reg.toggle;

endmodule

// File: rtl/key_debounce_ctrl.sv
// Multi-key debounce front end: NUM_KEYS independent channels whose
// outputs are packed bit-per-key.
module key_debounce_ctrl
   import key_pkg::*;
#(
   parameter int NUM_KEYS    = 4,
   parameter int DB_CYCLES   = KEY_DB_CYCLES_12M,
   parameter int DB_WIDTH    = KEY_DB_WIDTH,
   parameter int LONG_CYCLES = KEY_LONG_CYCLES_12M,
   parameter int LONG_WIDTH  = KEY_LONG_WIDTH
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_toggle
);

   generate
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         key_debounce_one #(
            .DB_CYCLES   (DB_CYCLES),
            .DB_WIDTH    (DB_WIDTH),
            .LONG_CYCLES (LONG_CYCLES),
            .LONG_WIDTH  (LONG_WIDTH)
         ) u_key (
            .clk         (clk),
            .rst         (rst),
            .key_n       (key_n[gi]),
            .key_level   (key_level[gi]),
            .key_press   (key_press[gi]),
            .key_release (key_release[gi]),
            .key_long    (key_long[gi]),
            .key_toggle  (key_toggle[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Directed bench for key_debounce_ctrl with short debounce/long timings.
module tb_key_debounce_ctrl;

   localparam int NK = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [NK-1:0] key_n;
   logic [NK-1:0] key_level, key_press, key_release, key_long, key_toggle;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   key_debounce_ctrl #(
      .NUM_KEYS    (NK),
      .DB_CYCLES   (4),
      .DB_WIDTH    (3),
      .LONG_CYCLES (16),
      .LONG_WIDTH  (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_n       (key_n),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long),
      .key_toggle  (key_toggle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic run_to(input int e);
      while (edge_n < e) tick();
   endtask

   function automatic logic [9:0] all_out();
      return {key_level, key_press, key_release, key_long, key_toggle};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  acc;
      logic        k0_bad;
      int          long_cnt;
      int          press1_cnt;

      rst   = 1'b1;
      key_n = 2'b11;
      repeat (3) tick();
      check("reset_level",   32'(key_level),   32'h0);
      check("reset_press",   32'(key_press),   32'h0);
      check("reset_release", 32'(key_release), 32'h0);
      check("reset_long",    32'(key_long),    32'h0);
      check("reset_toggle",  32'(key_toggle),  32'h0);
      rst = 1'b0;
      repeat (3) tick();

      // Bounce: 3-cycle low bursts never reach the 4-cycle threshold
      for (int b = 0; b < 5; b++) begin
         acc = '0;
         key_n[0] = 1'b0;
         repeat (3) begin tick(); acc |= {key_level[0], key_press[0], key_toggle[0]}; end
         key_n[0] = 1'b1;
         repeat (5) begin tick(); acc |= {key_level[0], key_press[0], key_toggle[0]}; end
         check($sformatf("bounce_%0d", b), 32'(acc), 32'h0);
      end

      // Clean press held into long press, then release
      key_n[0] = 1'b0;
      edge_n = 0;
      run_to(5);  check("press_e5_level", 32'(key_level[0]), 32'h0);
      run_to(6);  check("press_e6_level", 32'(key_level[0]), 32'h1);
                  check("press_e6_press", 32'(key_press),    32'h1);
                  check("press_e6_toggle", 32'(key_toggle),  32'h1);
      run_to(7);  check("press_e7_press", 32'(key_press),    32'h0);
      run_to(20); check("long_e20", 32'(key_long), 32'h0);
      run_to(21); check("long_e21", 32'(key_long), 32'h1);
      long_cnt = 0;
      while (edge_n < 40) begin
         tick();
         if (key_long[0]) long_cnt++;
      end
      check("long_no_repeat", 32'(long_cnt), 32'h0);
      key_n[0] = 1'b1;
      run_to(45); check("rel_e45_release", 32'(key_release), 32'h0);
                  check("rel_e45_level",   32'(key_level),   32'h1);
      run_to(46); check("rel_e46_release", 32'(key_release), 32'h1);
                  check("rel_e46_level",   32'(key_level),   32'h0);
      run_to(47); check("rel_e47_release", 32'(key_release), 32'h0);
                  check("rel_toggle_kept", 32'(key_toggle),  32'h1);

      // Toggle sequence on key 1; key 0 must stay quiet at level 0, toggle 1
      k0_bad = 1'b0;
      press1_cnt = 0;
      for (int p = 0; p < 3; p++) begin
         key_n[1] = 1'b0;
         repeat (8) begin
            tick();
            if ({key_level[0], key_press[0], key_release[0], key_long[0], key_toggle[0]} != 5'b00001)
               k0_bad = 1'b1;
            if (key_press[1]) press1_cnt++;
         end
         check($sformatf("toggle1_press%0d", p), 32'(key_toggle[1]), (p % 2 == 0) ? 32'h1 : 32'h0);
         key_n[1] = 1'b1;
         repeat (8) begin
            tick();
            if ({key_level[0], key_press[0], key_release[0], key_long[0], key_toggle[0]} != 5'b00001)
               k0_bad = 1'b1;
         end
      end
      check("toggle_key0_quiet", 32'(k0_bad), 32'h0);
      check("toggle_key1_presses", 32'(press1_cnt), 32'h3);

      // Simultaneous press on both keys
      key_n = 2'b00;
      edge_n = 0;
      run_to(5); check("simul_e5_press", 32'(key_press), 32'h0);
      run_to(6); check("simul_e6_press", 32'(key_press), 32'h3);
                 check("simul_e6_level", 32'(key_level), 32'h3);
      run_to(7); check("simul_e7_press", 32'(key_press), 32'h0);
                 check("simul_toggle",   32'(key_toggle), 32'h0);
      key_n = 2'b11;
      repeat (8) tick();
      check("simul_released", 32'(key_level), 32'h0);

      // Reset in the middle of a hold
      key_n[0] = 1'b0;
      edge_n = 0;
      run_to(6);  check("rsthold_e6_press", 32'(key_press), 32'h1);
                  check("rsthold_e6_toggle", 32'(key_toggle), 32'h1);
      run_to(10);
      rst = 1'b1;
      #1;
      check("rsthold_async_clear", 32'(all_out()), 32'h0);
      tick(); tick();
      check("rsthold_during", 32'(all_out()), 32'h0);
      rst = 1'b0;
      edge_n = 0;
      run_to(5); check("rsthold_r5_press", 32'(key_press), 32'h0);
      run_to(6); check("rsthold_r6_press", 32'(key_press), 32'h1);
                 check("rsthold_r6_level", 32'(key_level), 32'h1);
      run_to(7); check("rsthold_r7_press", 32'(key_press), 32'h0);
                 check("rsthold_toggle",   32'(key_toggle), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_debounce_ctrl.md
Name: key_debounce_ctrl

Overview:
Multi-key front end that turns raw, bouncing, active-low push-button pins into clean per-key level, press, release, long-press and toggle signals. Sits directly upstream of the 60-second counter. Its toggle output replaces the undebounced start/pause flag. Its long-press output gives a clean counter clear. Runs on the 12 MHz board clock.

Parameters:
NUM_KEYS, 4, number of independent key channels.
DB_CYCLES, 240_000, consecutive stable cycles required to accept a level change (20 ms at 12 MHz).
DB_WIDTH, 18, debounce counter width; must satisfy 2^DB_WIDTH > DB_CYCLES.
LONG_CYCLES, 12_000_000, debounced-held cycles before a long-press event (1 s).
LONG_WIDTH, 24, hold counter width; must satisfy 2^LONG_WIDTH > LONG_CYCLES.

Ports:
clk, input, 1, system clock (12 MHz).
rst, input, 1, asynchronous active-high reset; one clock domain only.
key_n, input, NUM_KEYS, raw key pins, 0 = pressed, asynchronous to clk.
key_level, output, NUM_KEYS, debounced state, 1 = pressed.
key_press, output, NUM_KEYS, one-cycle pulse on debounced press.
key_release, output, NUM_KEYS, one-cycle pulse on debounced release.
key_long, output, NUM_KEYS, one-cycle pulse once per press after LONG_CYCLES held.
key_toggle, output, NUM_KEYS, flips on every key_press (start/pause flag).

Behaviour:
- Reset: async, active-high. While rst=1, every key is forced to the released state:
  - sync flops = 1;
  - key_level, key_press, key_release, key_long, key_toggle = 0;
  - all counters = 0.
- Synchroniser: per key, 2-flop chain on key_n. The inverted second stage is key_s (1 = pressed).
- Debounce: per key, counter db_cnt[DB_WIDTH-1:0].
  - key_s == key_level: db_cnt <= 0.
  - key_s != key_level and db_cnt < DB_CYCLES-1: db_cnt <= db_cnt+1.
  - key_s != key_level and db_cnt == DB_CYCLES-1: key_level <= key_s, db_cnt <= 0.
  - Net effect: key_level flips on the edge ending the DB_CYCLES-th consecutive mismatch cycle.
  - Any single matching cycle restarts the count, so glitches shorter than DB_CYCLES never propagate.
- Latency: a clean raw pin transition appears on key_level exactly DB_CYCLES+2 clock edges later.
- Event pulses: all registered, updated on the same edge that changes key_level.
  - key_press=1 for exactly the first cycle key_level reads 1.
  - key_release=1 for exactly the first cycle key_level reads 0.
  - Pulses never overlap for a given key, since a minimum DB_CYCLES separates level changes.
- Toggle: key_toggle <= ~key_toggle on the same edge key_press is set; otherwise held.
- Long press: per key, hold_cnt[LONG_WIDTH-1:0].
  - Cleared on the press edge and while key_level=0.
  - Increments each cycle key_level=1 until it reaches LONG_CYCLES-1, then saturates.
  - key_long pulses one cycle on the increment edge into LONG_CYCLES-1, counting from the cycle key_press is high.
  - key_long never repeats while held; re-armed only by release.
  - Release after a long press still emits key_release.
- Independence: keys share no state. Simultaneous presses on several keys give simultaneous per-bit pulses.
- Reset mid-operation:
  - Pulses abort and the toggle returns to 0.
  - A key still held when rst deasserts is re-debounced from the released state, giving key_press DB_CYCLES+2 edges after rst falls.
- No combinational path from key_n to any output.

Decomposition:
- Package key_pkg holds:
  - KEY_DB_CYCLES_12M = 240_000 and KEY_LONG_CYCLES_12M = 12_000_000;
  - the width-derivation constants (clog2 of each);
  - KEY_PRESSED = 1'b0 (pin polarity).
- Natural sub-module: key_debounce_one, a single-key channel with sync, debounce counter, hold counter, pulses and toggle.
- key_debounce_ctrl generates NUM_KEYS instances and concatenates their outputs.

Test Plan:
(Bench overrides: DB_CYCLES=4, LONG_CYCLES=16, NUM_KEYS=2.)
- Clean press: key_n[0] 1->0 at edge 0, then held → key_level[0]=1 and key_press[0]=1 at edge 6, key_press[0]=0 at edge 7, key_toggle[0]=1.
- Bounce reject: key_n[0] low for 3 cycles, then high, repeated ×5 → key_level, key_press and key_toggle stay 0; db_cnt never exceeds 3.
- Long press: hold key_n[0]=0 for 40 cycles → key_press at edge 6, single key_long pulse at edge 21, no second pulse; on release, key_release pulses 6 edges after the pin rises.
- Toggle sequence: three clean press/release cycles on key 1 → key_toggle[1] goes 1, 0, 1; key 0 outputs unchanged throughout.
- Simultaneous keys: key_n=2'b00 on the same edge → key_press=2'b11 for exactly one cycle at edge 6.
- Reset mid-hold: key_n[0]=0 held, rst pulsed at edge 10 → all outputs 0 during reset; key_press[0] re-fires 6 edges after rst deasserts; key_toggle[0] ends at 1.
